ctu_dram_cken_seq: RTL and testbench

//  Clock-control-side sequencer driving the DRAM/DDR cluster-header inputs: per-cluster

---
 rtl/ctu_dram_cken_seq.sv | 185 ++++++++++++++++++
 tb/tb_ctu_dram_cken_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ctu_dram_cken_seq.sv
// DRAM/DDR cluster-header sequencer: staggered per-cluster clock enables, global
// reset release after all clusters clock, timed debug-init pulses and staggered shutdown.
module ctu_dram_cken_seq #(
  parameter int unsigned NCLUST   = 4,
  parameter int unsigned STAGGER  = 8,
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned DBG_HOLD = 4
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic              start,
  input  logic              stop_req,
  input  logic              dbg_req,
  input  logic [NCLUST-1:0] cken_mask,
  output logic [NCLUST-1:0] cluster_cken,
  output logic              grst_l,
  output logic              gdbginit_l,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_SR = (STAGGER > RST_HOLD) ? STAGGER : RST_HOLD;
  localparam int unsigned MAX_H  = (MAX_SR > DBG_HOLD) ? MAX_SR : DBG_HOLD;
  localparam int unsigned CW     = $clog2(MAX_H + 1);
  localparam int unsigned IW     = (NCLUST > 1) ? $clog2(NCLUST) : 1;

  localparam logic [CW-1:0] STG_LD = CW'(STAGGER - 1);
  localparam logic [CW-1:0] RST_LD = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] DBG_LD = CW'(DBG_HOLD - 1);
  localparam logic [IW-1:0] LAST   = IW'(NCLUST - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN,
    S_RWAIT,
    S_RUN,
    S_DBG,
    S_DIS
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NCLUST-1:0] mask_q, mask_d;
  logic [NCLUST-1:0] cken_q, cken_d;
  logic              grst_l_q, grst_l_d;
  logic              gdbg_q, gdbg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnt_zero;
  logic              stop_ok;

  assign cnt_zero = (cnt_q == '0);
  assign stop_ok  = stop_req && (state_q inside {S_EN, S_RWAIT, S_RUN, S_DBG});

  // Next-state and registered-output logic; counters load N-1 so edges land N cycles later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    cken_d   = cken_q;
    grst_l_d = grst_l_q;
    gdbg_d   = gdbg_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d    = cken_mask;
          cken_d    = '0;
          cken_d[0] = cken_mask[0];
          idx_d     = '0;
          if (NCLUST == 1) begin
            state_d = S_RWAIT;
            cnt_d   = RST_LD;
          end else begin
            state_d = S_EN;
            cnt_d   = STG_LD;
          end
        end
      end
      S_EN: begin
        if (cnt_zero) begin
          idx_d         = (idx_q == LAST) ? idx_q : idx_q + IW'(1);
          cken_d[idx_d] = mask_q[idx_d];
          if (idx_d == LAST) begin
            state_d = S_RWAIT;
            cnt_d   = RST_LD;
          end else begin
            cnt_d = STG_LD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RWAIT: begin
        if (cnt_zero) begin
          state_d  = S_RUN;
          grst_l_d = 1'b1;
          gdbg_d   = 1'b1;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        if (dbg_req) begin
          state_d = S_DBG;
          gdbg_d  = 1'b0;
          cnt_d   = DBG_LD;
        end
      end
      S_DBG: begin
        if (cnt_zero) begin
          state_d = S_RUN;
          gdbg_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIS: begin
        if (cnt_zero) begin
          cken_d[LAST - idx_q] = 1'b0;
          if (idx_q == LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
            cnt_d = STG_LD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shutdown pre-empts any in-flight step; a pending slot edge is abandoned.
    if (stop_ok) begin
      state_d  = S_DIS;
      cken_d   = cken_q;
      grst_l_d = 1'b0;
      gdbg_d   = 1'b0;
      cnt_d    = STG_LD;
      idx_d    = '0;
      done_d   = 1'b0;
    end

    busy_d = state_d inside {S_EN, S_RWAIT, S_DBG, S_DIS};
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
      cken_q   <= '0;
      grst_l_q <= 1'b0;
      gdbg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      cken_q   <= cken_d;
      grst_l_q <= grst_l_d;
      gdbg_q   <= gdbg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cluster_cken = cken_q;
  assign grst_l       = grst_l_q;
  assign gdbginit_l   = gdbg_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ctu_dram_cken_seq.sv
// Scoreboard bench for ctu_dram_cken_seq: stimulus queues cycle-stamped output
// snapshots, a negedge monitor pops and compares them as the DUT reaches each cycle.
module tb_ctu_dram_cken_seq;

  logic       gclk = 1'b0;
  logic       grst;
  logic       start;
  logic       stop_req;
  logic       dbg_req;
  logic [3:0] cken_mask;
  logic [3:0] cluster_cken;
  logic       grst_l;
  logic       gdbginit_l;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [3:0] cken;
    logic       gl;
    logic       gd;
    logic       bz;
    logic       dn;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  ctu_dram_cken_seq #(
    .NCLUST(4), .STAGGER(8), .RST_HOLD(16), .DBG_HOLD(4)
  ) dut (
    .gclk(gclk), .grst(grst), .start(start), .stop_req(stop_req), .dbg_req(dbg_req),
    .cken_mask(cken_mask), .cluster_cken(cluster_cken), .grst_l(grst_l),
    .gdbginit_l(gdbginit_l), .busy(busy), .done(done)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  function automatic void expect_at(int c, logic [3:0] ck, logic gl, logic gd, logic bz,
                                    logic dn, string nm);
    exp_t e;
    e.c = c; e.cken = ck; e.gl = gl; e.gd = gd; e.bz = bz; e.dn = dn; e.nm = nm;
    exp_q.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  // Monitor: compare every snapshot whose cycle has been reached.
  logic prev_done = 1'b0;
  always @(negedge gclk) begin
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.c != cyc || cluster_cken !== e.cken || grst_l !== e.gl || gdbginit_l !== e.gd ||
          busy !== e.bz || done !== e.dn) begin
        errors++;
        $display("FAIL %s cyc=%0d(want %0d) got cken=%b grst_l=%b gdbg=%b busy=%b done=%b want cken=%b grst_l=%b gdbg=%b busy=%b done=%b",
                 e.nm, cyc, e.c, cluster_cken, grst_l, gdbginit_l, busy, done,
                 e.cken, e.gl, e.gd, e.bz, e.dn);
      end
    end
    if (cyc > 2) begin
      checks++;
      if (done === 1'b1 && prev_done === 1'b1) begin
        errors++;
        $display("FAIL done_back_to_back cyc=%0d got done=1 twice want single pulse", cyc);
      end
    end
    prev_done = done;
  end

  int t;

  initial begin
    // 1: reset with random inputs
    grst = 1'b1;
    start = 1'($urandom); stop_req = 1'($urandom); dbg_req = 1'($urandom);
    cken_mask = 4'($urandom);
    expect_at(1, 4'b0000, 0, 0, 0, 0, "reset_c1");
    expect_at(2, 4'b0000, 0, 0, 0, 0, "reset_c2");
    step(1);
    start = 1'($urandom); stop_req = 1'($urandom); dbg_req = 1'($urandom);
    cken_mask = 4'($urandom);
    step(1);
    grst = 1'b0; start = 1'b0; stop_req = 1'b0; dbg_req = 1'b0; cken_mask = 4'b0000;
    step(2);

    // 2: power-up with full mask
    t = cyc;
    start = 1'b1; cken_mask = 4'b1111;
    expect_at(t + 1,  4'b0001, 0, 0, 1, 0, "up_slot0");
    expect_at(t + 8,  4'b0001, 0, 0, 1, 0, "up_pre_slot1");
    expect_at(t + 9,  4'b0011, 0, 0, 1, 0, "up_slot1");
    expect_at(t + 17, 4'b0111, 0, 0, 1, 0, "up_slot2");
    expect_at(t + 25, 4'b1111, 0, 0, 1, 0, "up_slot3");
    expect_at(t + 40, 4'b1111, 0, 0, 1, 0, "up_rwait_end");
    expect_at(t + 41, 4'b1111, 1, 1, 0, 1, "up_release");
    expect_at(t + 42, 4'b1111, 1, 1, 0, 0, "up_run");
    step(1);
    start = 1'b0; cken_mask = 4'b0000;
    step(44);

    // 3: debug pulse, second request during DBG dropped
    t = cyc;
    dbg_req = 1'b1;
    expect_at(t + 1, 4'b1111, 1, 0, 1, 0, "dbg_low_first");
    expect_at(t + 4, 4'b1111, 1, 0, 1, 0, "dbg_low_last");
    expect_at(t + 5, 4'b1111, 1, 1, 0, 1, "dbg_release");
    expect_at(t + 6, 4'b1111, 1, 1, 0, 0, "dbg_run");
    step(2);
    dbg_req = 1'b0;
    step(8);

    // 4: stop and dbg together, stop wins
    t = cyc;
    stop_req = 1'b1; dbg_req = 1'b1;
    expect_at(t + 1,  4'b1111, 0, 0, 1, 0, "dis_start");
    expect_at(t + 8,  4'b1111, 0, 0, 1, 0, "dis_pre_drop3");
    expect_at(t + 9,  4'b0111, 0, 0, 1, 0, "dis_drop3");
    expect_at(t + 17, 4'b0011, 0, 0, 1, 0, "dis_drop2");
    expect_at(t + 25, 4'b0001, 0, 0, 1, 0, "dis_drop1");
    expect_at(t + 32, 4'b0001, 0, 0, 1, 0, "dis_pre_drop0");
    expect_at(t + 33, 4'b0000, 0, 0, 0, 1, "dis_done");
    expect_at(t + 34, 4'b0000, 0, 0, 0, 0, "dis_idle");
    step(1);
    stop_req = 1'b0; dbg_req = 1'b0;
    step(36);

    // 5: sparse mask, late mask change ignored, stop mid-EN
    t = cyc;
    start = 1'b1; cken_mask = 4'b1010;
    expect_at(t + 1,  4'b0000, 0, 0, 1, 0, "sp_slot0_masked");
    expect_at(t + 9,  4'b0010, 0, 0, 1, 0, "sp_slot1");
    expect_at(t + 11, 4'b0010, 0, 0, 1, 0, "sp_dis_start");
    expect_at(t + 27, 4'b0010, 0, 0, 1, 0, "sp_no_slot3");
    expect_at(t + 34, 4'b0010, 0, 0, 1, 0, "sp_pre_drop1");
    expect_at(t + 35, 4'b0000, 0, 0, 1, 0, "sp_drop1");
    expect_at(t + 43, 4'b0000, 0, 0, 0, 1, "sp_done");
    step(1);
    start = 1'b0; cken_mask = 4'b1111;
    step(9);
    stop_req = 1'b1;
    step(1);
    stop_req = 1'b0;
    step(36);

    // 6: reset mid-EN, then restart from slot 0
    t = cyc;
    start = 1'b1; cken_mask = 4'b1111;
    expect_at(t + 20, 4'b0111, 0, 0, 1, 0, "mid_en");
    expect_at(t + 21, 4'b0000, 0, 0, 0, 0, "mid_reset");
    step(1);
    start = 1'b0;
    step(19);
    grst = 1'b1;
    step(1);
    grst = 1'b0;
    step(3);
    t = cyc;
    start = 1'b1; cken_mask = 4'b0101;
    expect_at(t + 1,  4'b0001, 0, 0, 1, 0, "re_slot0");
    expect_at(t + 9,  4'b0001, 0, 0, 1, 0, "re_slot1_masked");
    expect_at(t + 17, 4'b0101, 0, 0, 1, 0, "re_slot2");
    expect_at(t + 41, 4'b0101, 1, 1, 0, 1, "re_release");
    step(1);
    start = 1'b0;
    step(45);

    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
